vc_output_ctrl: RTL and testbench
=================================

# vc_output_ctrl

Parametrised router output-port controller: selects one of N_IN granted input channels, buffers the flit in one of two polarity-indexed virtual-channel FIFOs (even/odd), and drains the opposite-polarity FIFO downstream under a ready handshake. It sits between the per-port arbiter and the output link of each router port. It generalises the single-register even/odd output stage to configurable width, input count and per-VC buffer depth, and adds occupancy reporting and grant-error detection.

## Interface
- DATA_W, 64, flit width in bits
- N_IN, 5, number of input channels (bit 0 = PE, then S, N, E, W for a 5-port router)
- DEPTH, 2, entries per VC FIFO; power of two, ≥1
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- polarity  in  1  0 = even phase (write even VC, read odd VC), 1 = odd phase (write odd VC, read even VC)
- grant  in  N_IN  one-hot grant from arbiter; all-zero = no request
- data_in  in  N_IN*DATA_W  flattened inputs; channel i at [i*DATA_W +: DATA_W]
- receive_output  in  1  downstream ready
- data_out  out  DATA_W  head flit of read-phase VC; 0 when send_output=0
- send_output  out  1  data_out valid and accepted this cycle
- in_ready  out  1  write-phase VC has at least one free entry
- clear  out  N_IN  per-input acknowledge; clear[i]=1 means channel i's flit is taken this cycle
- grant_err  out  1  registered; 1 for one cycle after a non-one-hot, non-zero grant
- cnt_even, cnt_odd  out  CNT_W  registered occupancy of each VC

## Operation
- Write VC = polarity; read VC = ~polarity. Same FIFO never pushed and popped in one cycle.
- Push: grant one-hot AND write VC not full → data_in of granted channel written at write pointer; write pointer +1 mod DEPTH; count +1.
- clear = grant when push condition true, else all-zero (combinational, same cycle as grant).
- Non-one-hot non-zero grant: no push, clear=0, grant_err=1 next cycle.
- Grant with write VC full: no push, clear=0, grant_err stays 0; upstream holds flit.
- Pop: receive_output=1 AND read VC not empty → send_output=1, data_out=head; read pointer +1 mod DEPTH; count −1 at edge.
- receive_output=0 or read VC empty → send_output=0, data_out=0, no state change in read VC.
- in_ready = (count of write VC < DEPTH), combinational on polarity.
- Pointers wrap modulo DEPTH; full when count=DEPTH, empty when count=0; FIFO order preserved per VC.
- No polarity-toggle assumption: if polarity holds, the same VC keeps filling and the other keeps draining.

## Timing
- Reset (sync): both FIFOs empty, pointers 0, cnt_even=cnt_odd=0, grant_err=0. Combinational consequence: in_ready=1, send_output=0, data_out=0, clear=0.
- Reset has priority over push/pop in the same cycle; in-flight contents discarded, no clear asserted in a reset cycle.
- Push latency: flit granted in cycle t (polarity p) is poppable in the first cycle t'>t with polarity ~p; minimum 1 cycle with alternating polarity.
- Throughput: 1 flit/cycle in and 1 flit/cycle out concurrently with alternating polarity.
- clear, in_ready, send_output, data_out are combinational from current-cycle inputs and registered state; cnt_*, grant_err are registered.

## Test plan
- Reset then idle: reset high 2 cycles → in_ready=1, send_output=0, data_out=0, clear=0, cnt_even=cnt_odd=0, grant_err=0.
- Basic pass-through (DEPTH=2): cycle 0 polarity=0, grant=5'b00100, N data=64'hA5A5 → clear=5'b00100, cnt_even=1; cycle 1 polarity=1, receive_output=1 → send_output=1, data_out=64'hA5A5, cnt_even=0 after edge.
- Fill and backpressure: polarity held 0, grants on PE with 64'h1,64'h2,64'h3 → first two cleared, third clear=0, in_ready=0, cnt_even=2; then polarity=1, receive_output=1 two cycles → data_out 64'h1 then 64'h2, FIFO order kept.
- Downstream stall: odd VC holds 64'hBEEF, polarity=0, receive_output=0 for 3 cycles → send_output=0, data_out=0, cnt_odd=1; receive_output=1 → 64'hBEEF sent.
- Bad grant: grant=5'b00011 → clear=0, no push, grant_err=1 next cycle only, counts unchanged.
- Reset mid-operation: both VCs holding data, reset one cycle with grant=5'b00001 → no clear, counts 0, send_output=0 after reset.

Source files
------------

// File: rtl/vc_output_ctrl_if.sv
// Bundle between the per-port arbiter, the output link and the even/odd VC output stage.
interface vc_output_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned N_IN   = 5,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                     polarity;
  logic [N_IN-1:0]          grant;
  logic [N_IN*DATA_W-1:0]   data_in;
  logic                     receive_output;
  logic [DATA_W-1:0]        data_out;
  logic                     send_output;
  logic                     in_ready;
  logic [N_IN-1:0]          clear;
  logic                     grant_err;
  logic [CNT_W-1:0]         cnt_even;
  logic [CNT_W-1:0]         cnt_odd;

  // Arbiter/link side: drives grants, flits, phase and downstream ready.
  modport master (
    output polarity, grant, data_in, receive_output,
    input  data_out, send_output, in_ready, clear, grant_err, cnt_even, cnt_odd
  );

  // Output controller side.
  modport slave (
    input  polarity, grant, data_in, receive_output,
    output data_out, send_output, in_ready, clear, grant_err, cnt_even, cnt_odd
  );
endinterface

// File: rtl/vc_output_ctrl.sv
// Router output-port controller: one-hot grant selects an input flit, which is pushed into the
// write-phase VC FIFO (index = polarity) while the read-phase VC FIFO (index = ~polarity) drains
// downstream under a ready handshake. Reports per-VC occupancy and malformed grants.
module vc_output_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned N_IN   = 5,
  parameter int unsigned DEPTH  = 2
) (
  input logic              clk,
  input logic              reset,
  vc_output_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];
  logic              grant_err_q;
  logic              grant_err_d;

  logic              wr_vc;
  logic              rd_vc;
  logic              grant_zero;
  logic              grant_onehot;
  logic              wr_full;
  logic              rd_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sel_flit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Decode grant and FIFO status; reset suppresses any push/pop in its cycle.
  always_comb begin
    wr_vc        = bus.polarity;
    rd_vc        = ~bus.polarity;
    grant_zero   = (bus.grant == '0);
    grant_onehot = !grant_zero && ((bus.grant & (bus.grant - N_IN'(1))) == '0);
    wr_full      = (cnt_q[wr_vc] == CNT_W'(DEPTH));
    rd_empty     = (cnt_q[rd_vc] == '0);
    push         = grant_onehot && !wr_full && !reset;
    pop          = bus.receive_output && !rd_empty && !reset;
  end

  // AND-OR mux of the granted channel; only meaningful when the grant is one-hot.
  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus.grant[i]) sel_flit |= bus.data_in[i*DATA_W +: DATA_W];
    end
  end

  // Next-state for pointers, counts and the grant error flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    grant_err_d = !grant_zero && !grant_onehot;
    // wr_vc != rd_vc, so a count is never incremented and decremented together.
    if (push) begin
      wr_ptr_d[wr_vc] = ptr_inc(wr_ptr_q[wr_vc]);
      cnt_d[wr_vc]    = cnt_q[wr_vc] + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d[rd_vc] = ptr_inc(rd_ptr_q[rd_vc]);
      cnt_d[rd_vc]    = cnt_q[rd_vc] - CNT_W'(1);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      grant_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      grant_err_q <= grant_err_d;
    end
  end

  // Flit storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_vc][wr_ptr_q[wr_vc]] <= sel_flit;
  end

  // Handshake outputs and status.
  always_comb begin
    bus.clear       = push ? bus.grant : '0;
    bus.send_output = pop;
    bus.data_out    = pop ? mem_q[rd_vc][rd_ptr_q[rd_vc]] : '0;
    bus.in_ready    = (cnt_q[wr_vc] < CNT_W'(DEPTH));
    bus.grant_err   = grant_err_q;
    bus.cnt_even    = cnt_q[0];
    bus.cnt_odd     = cnt_q[1];
  end

endmodule

// File: tb/tb_vc_output_ctrl.sv
// Table-driven bench for vc_output_ctrl with a per-VC scoreboard for flit data and order.
module tb_vc_output_ctrl;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned N_IN   = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NV     = 21;

  typedef struct packed {
    logic        pol;
    logic [4:0]  grant;
    logic [63:0] flit;
    logic        rcv;
    logic [4:0]  clr;   // expected clear (pre-edge)
    logic        snd;   // expected send_output (pre-edge)
    logic        rdy;   // expected in_ready (pre-edge)
    logic [1:0]  ce;    // expected cnt_even after edge
    logic [1:0]  co;    // expected cnt_odd after edge
    logic        err;   // expected grant_err after edge
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] q_even[$];
  logic [63:0] q_odd[$];
  vec_t        tbl[NV];

  vc_output_ctrl_if #(.DATA_W(DATA_W), .N_IN(N_IN), .DEPTH(DEPTH)) bus ();

  vc_output_ctrl #(.DATA_W(DATA_W), .N_IN(N_IN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Non-granted channels carry a distinct pattern so a wrong mux select is visible.
  task automatic drive(input logic pol, input logic [4:0] g, input logic [63:0] flit,
                       input logic rcv);
    bus.polarity       = pol;
    bus.grant          = g;
    bus.receive_output = rcv;
    for (int i = 0; i < N_IN; i++) begin
      bus.data_in[i*DATA_W +: DATA_W] = g[i] ? flit : (~flit ^ 64'(i + 1));
    end
  endtask

  // Compare data_out against the scoreboard whenever the DUT sends.
  task automatic check_send(input logic rd_vc);
    logic [63:0] exp;
    if (bus.send_output) begin
      if ((rd_vc ? q_odd.size() : q_even.size()) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got send_output=1 want nothing queued to send");
      end else begin
        exp = rd_vc ? q_odd.pop_front() : q_even.pop_front();
        chk("data_out", bus.data_out, exp);
      end
    end else begin
      chk("data_out_idle", bus.data_out, 64'h0);
    end
  endtask

  // Called just after a rising edge: apply, check combinational outputs, clock, check registers.
  task automatic run_vec(input vec_t v, input int idx);
    drive(v.pol, v.grant, v.flit, v.rcv);
    #4;
    chk($sformatf("v%0d clear", idx), 64'(bus.clear), 64'(v.clr));
    chk($sformatf("v%0d in_ready", idx), 64'(bus.in_ready), 64'(v.rdy));
    chk($sformatf("v%0d send", idx), 64'(bus.send_output), 64'(v.snd));
    check_send(~v.pol);
    if (v.clr != '0) begin
      if (v.pol) q_odd.push_back(v.flit);
      else       q_even.push_back(v.flit);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cnt_even", idx), 64'(bus.cnt_even), 64'(v.ce));
    chk($sformatf("v%0d cnt_odd", idx), 64'(bus.cnt_odd), 64'(v.co));
    chk($sformatf("v%0d grant_err", idx), 64'(bus.grant_err), 64'(v.err));
  endtask

  initial begin
    //            pol  grant     flit         rcv  clr       snd  rdy  ce    co    err
    tbl[0]  = '{1'b0, 5'b00100, 64'hA5A5,    1'b0, 5'b00100, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 5'b00000, 64'h0,       1'b1, 5'b00000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 5'b00001, 64'h1,       1'b0, 5'b00001, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 5'b00001, 64'h2,       1'b1, 5'b00001, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 5'b00001, 64'h3,       1'b0, 5'b00000, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 5'b00000, 64'h0,       1'b1, 5'b00000, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 5'b10000, 64'h10,      1'b1, 5'b10000, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 5'b01000, 64'h20,      1'b1, 5'b01000, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 5'b00010, 64'hBEEF,    1'b1, 5'b00010, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[9]  = '{1'b1, 5'b00011, 64'h40,      1'b0, 5'b00000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 5'b00000, 64'h0,       1'b0, 5'b00000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 5'b00000, 64'h0,       1'b0, 5'b00000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 5'b00000, 64'h0,       1'b0, 5'b00000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 5'b00000, 64'h0,       1'b0, 5'b00000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 5'b00000, 64'h0,       1'b1, 5'b00000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[15] = '{1'b1, 5'b00100, 64'h50,      1'b1, 5'b00100, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[16] = '{1'b1, 5'b00100, 64'h51,      1'b0, 5'b00100, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
    tbl[17] = '{1'b1, 5'b00100, 64'h52,      1'b0, 5'b00000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0};
    tbl[18] = '{1'b0, 5'b00001, 64'h60,      1'b0, 5'b00001, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0};
    // After the mid-operation reset: pointers must restart at 0.
    tbl[19] = '{1'b0, 5'b01000, 64'h77,      1'b1, 5'b01000, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[20] = '{1'b1, 5'b00000, 64'h0,       1'b1, 5'b00000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};

    // Reset held two cycles, then idle outputs.
    reset = 1'b1;
    drive(1'b0, 5'b00000, 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst send", 64'(bus.send_output), 64'h0);
    chk("rst data_out", bus.data_out, 64'h0);
    chk("rst clear", 64'(bus.clear), 64'h0);
    chk("rst cnt_even", 64'(bus.cnt_even), 64'h0);
    chk("rst cnt_odd", 64'(bus.cnt_odd), 64'h0);
    chk("rst grant_err", 64'(bus.grant_err), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], i);

    // Reset while both VCs hold data, with a live grant and ready.
    reset = 1'b1;
    drive(1'b0, 5'b00001, 64'h70, 1'b1);
    #4;
    chk("mrst clear", 64'(bus.clear), 64'h0);
    chk("mrst send", 64'(bus.send_output), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_even.delete();
    q_odd.delete();
    chk("mrst cnt_even", 64'(bus.cnt_even), 64'h0);
    chk("mrst cnt_odd", 64'(bus.cnt_odd), 64'h0);
    drive(1'b1, 5'b00000, 64'h0, 1'b1);
    #4;
    chk("mrst send_even", 64'(bus.send_output), 64'h0);
    chk("mrst data_out", bus.data_out, 64'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'b00000, 64'h0, 1'b1);
    #4;
    chk("mrst send_odd", 64'(bus.send_output), 64'h0);
    @(posedge clk);
    #1;

    for (int i = 19; i < NV; i++) run_vec(tbl[i], i);

    chk("sb_even_empty", 64'(q_even.size()), 64'h0);
    chk("sb_odd_empty", 64'(q_odd.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
